// File: rtl/core_seq_ctrl_if.sv
// Host/core handshake bundle for the instruction sequencer.
// The master side drives start and ofifo_valid; the slave side produces the instruction word and status.
interface core_seq_ctrl_if;
    logic        start;
    logic        ofifo_valid;
    logic [33:0] inst;
    logic        busy;
    logic        done;
    logic        err;
    logic [3:0]  kij;

    modport master (
        output start, ofifo_valid,
        input  inst, busy, done, err, kij
    );

    modport slave (
        input  start, ofifo_valid,
        output inst, busy, done, err, kij
    );
endinterface

// File: rtl/core_seq_ctrl.sv
// Sequencer that emits the 34-bit core instruction word for every kernel offset:
// weight load, kernel load, idle gap, then activation execute while draining OFIFO rows to psum SRAM.
module core_seq_ctrl #(
    parameter int ROW       = 8,
    parameter int COL       = 8,
    parameter int LEN_NIJ   = 36,
    parameter int LEN_KIJ   = 9,
    parameter int W_BASE    = 1024,
    parameter int PSUM_BASE = 0,
    parameter int GAP_CYC   = 10,
    parameter int DRAIN_MAX = 64
) (
    input  logic            clk,
    input  logic            reset,
    core_seq_ctrl_if.slave  bus
);

    localparam int PMAX0 = (LEN_NIJ + 2 > COL + ROW + 1) ? LEN_NIJ + 2 : COL + ROW + 1;
    localparam int PMAX  = (PMAX0 > GAP_CYC) ? PMAX0 : GAP_CYC;
    localparam int CW    = $clog2(PMAX + 1);
    localparam int RW    = $clog2(LEN_NIJ + 1);
    localparam int DW    = $clog2(DRAIN_MAX + 1);

    localparam logic [CW-1:0] C_COL      = CW'(COL);
    localparam logic [CW-1:0] C_LOAD_END = CW'(COL + ROW - 1);
    localparam logic [CW-1:0] C_GAP_END  = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] C_NIJ      = CW'(LEN_NIJ);
    localparam logic [CW-1:0] C_ACT_END  = CW'(LEN_NIJ + 1);
    localparam logic [CW-1:0] C_ONE      = CW'(1);
    localparam logic [CW-1:0] C_TWO      = CW'(2);
    localparam logic [RW-1:0] C_ROWS     = RW'(LEN_NIJ);
    localparam logic [DW-1:0] C_DRN_END  = DW'(DRAIN_MAX - 1);
    localparam logic [3:0]    C_KIJ_END  = 4'(LEN_KIJ - 1);

    localparam logic [33:0] INST_IDLE = 34'h1_800C_0000;

    typedef enum logic [2:0] {
        S_IDLE, S_L0W, S_LOAD, S_GAP, S_ACT, S_DRAIN, S_NEXT
    } state_t;

    state_t          r_state, w_state_nx;
    logic [CW-1:0]   r_cnt, w_cnt_nx;
    logic [RW-1:0]   r_rows, w_rows_nx;
    logic [DW-1:0]   r_dcnt, w_dcnt_nx;
    logic [3:0]      r_kij, w_kij_nx;
    logic            r_busy, w_busy_nx;
    logic            r_done, w_done_nx;
    logic            r_err, w_err_nx;
    logic [33:0]     r_inst, w_inst_nx;

    logic            w_cen_x, w_l0_wr, w_l0_rd, w_exe, w_ld;
    logic            w_ofifo_rd, w_cen_p, w_wen_p;
    logic [10:0]     w_ax, w_ap;
    logic [10:0]     w_wt_addr, w_ps_addr;

    assign w_wt_addr = 11'(W_BASE + int'(r_kij) * COL + int'(r_cnt));
    assign w_ps_addr = 11'(PSUM_BASE + int'(r_kij) * LEN_NIJ + int'(r_rows));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_rows  <= '0;
            r_dcnt  <= '0;
            r_kij   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_inst  <= INST_IDLE;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_rows  <= w_rows_nx;
            r_dcnt  <= w_dcnt_nx;
            r_kij   <= w_kij_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
            r_err   <= w_err_nx;
            r_inst  <= w_inst_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_rows_nx  = r_rows;
        w_dcnt_nx  = r_dcnt;
        w_kij_nx   = r_kij;
        w_busy_nx  = r_busy;
        w_done_nx  = 1'b0;
        w_err_nx   = r_err;
        w_cen_x    = 1'b1;
        w_ax       = '0;
        w_l0_wr    = 1'b0;
        w_l0_rd    = 1'b0;
        w_exe      = 1'b0;
        w_ld       = 1'b0;
        w_ofifo_rd = 1'b0;
        w_cen_p    = 1'b1;
        w_wen_p    = 1'b1;
        w_ap       = '0;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nx = S_L0W;
                    w_cnt_nx   = '0;
                    w_rows_nx  = '0;
                    w_dcnt_nx  = '0;
                    w_kij_nx   = '0;
                    w_busy_nx  = 1'b1;
                    w_err_nx   = 1'b0;
                end
            end
            S_L0W: begin
                // L0 write trails the xmem read by one cycle to cover SRAM read latency.
                if (r_cnt < C_COL) begin
                    w_cen_x = 1'b0;
                    w_ax    = w_wt_addr;
                end
                w_l0_wr = (r_cnt >= C_ONE);
                if (r_cnt == C_COL) begin
                    w_state_nx = S_LOAD;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            S_LOAD: begin
                w_l0_rd = 1'b1;
                w_ld    = 1'b1;
                if (r_cnt == C_LOAD_END) begin
                    w_state_nx = S_GAP;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            S_GAP: begin
                if (r_cnt == C_GAP_END) begin
                    w_state_nx = S_ACT;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            S_ACT: begin
                if (r_cnt < C_NIJ) begin
                    w_cen_x = 1'b0;
                    w_ax    = 11'(r_cnt);
                end
                w_l0_wr = (r_cnt >= C_ONE) && (r_cnt <= C_NIJ);
                w_l0_rd = (r_cnt >= C_TWO);
                w_exe   = (r_cnt >= C_TWO);
                if (r_cnt == C_ACT_END) begin
                    w_state_nx = S_DRAIN;
                    w_cnt_nx   = '0;
                    w_dcnt_nx  = '0;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            S_DRAIN: begin
                if (r_rows >= C_ROWS) begin
                    w_state_nx = S_NEXT;
                end else if (r_dcnt == C_DRN_END) begin
                    w_err_nx   = 1'b1;
                    w_done_nx  = 1'b1;
                    w_busy_nx  = 1'b0;
                    w_state_nx = S_IDLE;
                end else begin
                    w_dcnt_nx = r_dcnt + 1'b1;
                end
            end
            S_NEXT: begin
                if (r_kij == C_KIJ_END) begin
                    w_done_nx  = 1'b1;
                    w_busy_nx  = 1'b0;
                    w_state_nx = S_IDLE;
                end else begin
                    w_kij_nx   = r_kij + 1'b1;
                    w_cnt_nx   = '0;
                    w_rows_nx  = '0;
                    w_state_nx = S_L0W;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase

        // OFIFO drain runs alongside ACT and DRAIN; rows beyond one tile are ignored.
        if ((r_state == S_ACT || r_state == S_DRAIN) && bus.ofifo_valid && (r_rows < C_ROWS)) begin
            w_ofifo_rd = 1'b1;
            w_cen_p    = 1'b0;
            w_wen_p    = 1'b0;
            w_ap       = w_ps_addr;
            w_rows_nx  = r_rows + 1'b1;
        end

        w_inst_nx = {1'b0, w_cen_p, w_wen_p, w_ap, w_cen_x, 1'b1, w_ax,
                     w_ofifo_rd, 1'b0, 1'b0, w_l0_rd, w_l0_wr, w_exe, w_ld};
    end

    assign bus.inst = r_inst;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.err  = r_err;
    assign bus.kij  = r_kij;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Randomized bench for core_seq_ctrl against a timeline model of one run.
// Each kij segment is an offset-indexed schedule followed by an open-ended drain phase.
module tb_core_seq_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    core_seq_ctrl_if bus();
    core_seq_ctrl dut (.clk(clk), .reset(reset), .bus(bus.slave));

    localparam logic [33:0] IDLE_W = 34'h1_800C_0000;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // model state: position within the kij segment (0..72 fixed schedule, >=73 drain)
    bit m_run, m_next, m_err;
    int m_pos, m_kij, m_rows;
    logic [33:0] e_inst;
    bit e_done;
    int mode, bc;
    bit noise;
    int pmem_wr, done_cnt;

    function automatic logic [33:0] sched(input int pos, input int k);
        logic cx, wr, rd, ex, ld;
        logic [10:0] ax;
        cx = 1; wr = 0; rd = 0; ex = 0; ld = 0; ax = '0;
        if (pos <= 8) begin
            if (pos < 8) begin cx = 0; ax = 11'(1024 + k * 8 + pos); end
            wr = (pos >= 1);
        end else if (pos <= 24) begin
            rd = 1; ld = 1;
        end else if (pos >= 35 && pos <= 72) begin
            if (pos - 35 < 36) begin cx = 0; ax = 11'(pos - 35); end
            wr = (pos - 35 >= 1) && (pos - 35 <= 36);
            rd = (pos - 35 >= 2);
            ex = rd;
        end
        return {1'b0, 1'b1, 1'b1, 11'd0, cx, 1'b1, ax, 1'b0, 2'b00, rd, wr, ex, ld};
    endfunction

    task automatic model_edge();
        int r0;
        e_done = 0;
        if (!m_run) begin
            e_inst = IDLE_W;
            if (bus.start) begin
                m_run = 1; m_pos = 0; m_kij = 0; m_rows = 0; m_next = 0; m_err = 0;
            end
        end else begin
            r0 = m_rows;
            e_inst = m_next ? IDLE_W : sched(m_pos, m_kij);
            if (!m_next && m_pos >= 35 && bus.ofifo_valid && m_rows < 36) begin
                e_inst[6] = 1'b1;
                e_inst[32] = 1'b0;
                e_inst[31] = 1'b0;
                e_inst[30:20] = 11'(m_kij * 36 + m_rows);
                m_rows++;
            end
            if (m_next) begin
                if (m_kij == 8) begin e_done = 1; m_run = 0; end
                else begin m_kij++; m_pos = 0; m_rows = 0; m_next = 0; end
            end else if (m_pos < 73) m_pos++;
            else if (r0 >= 36) m_next = 1;
            else if (m_pos - 73 == 63) begin m_err = 1; e_done = 1; m_run = 0; end
            else m_pos++;
        end
    endtask

    task automatic drive();
        case (mode)
            0: bus.ofifo_valid = ($urandom_range(0, 9) < 7);
            1: begin bus.ofifo_valid = (bc % 3) != 2; bc++; end
            2: bus.ofifo_valid = (m_rows < 30);
            default: bus.ofifo_valid = 1'b1;
        endcase
        bus.start = (noise && m_run) ? ($urandom_range(0, 3) == 0) : 1'b0;
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        chk("inst", 64'(bus.inst), 64'(e_inst));
        chk("busy", 64'(bus.busy), 64'(m_run));
        chk("done", 64'(bus.done), 64'(e_done));
        chk("err", 64'(bus.err), 64'(m_err));
        chk("kij", 64'(bus.kij), 64'(m_kij));
        if (bus.inst[31] == 1'b0) pmem_wr++;
        if (bus.done) done_cnt++;
        drive();
    endtask

    task automatic run(input int md, input bit nz, input int exp_wr);
        int n;
        mode = md; noise = nz; bc = 0; pmem_wr = 0; done_cnt = 0; n = 0;
        bus.start = 1'b1;
        bus.ofifo_valid = 1'b0;
        do begin cyc(); n++; end while (m_run && n < 3000);
        chk("run_bound", 64'(n < 3000), 64'(1));
        chk("done_cnt", 64'(done_cnt), 64'(1));
        if (exp_wr >= 0) chk("pmem_wr", 64'(pmem_wr), 64'(exp_wr));
        noise = 0;
        bus.start = 1'b0;
        repeat (3) cyc();
    endtask

    initial begin
        m_run = 0; m_next = 0; m_err = 0; m_pos = 0; m_kij = 0; m_rows = 0;
        mode = 0; noise = 0; bc = 0;
        reset = 1'b0;
        bus.start = 1'b0;
        bus.ofifo_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.start = 1'($urandom_range(0, 1));
            bus.ofifo_valid = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            chk("rst_inst", 64'(bus.inst), 64'(IDLE_W));
            chk("rst_busy", 64'(bus.busy), 64'(0));
            chk("rst_done", 64'(bus.done), 64'(0));
            chk("rst_kij", 64'(bus.kij), 64'(0));
            chk("rst_err", 64'(bus.err), 64'(0));
        end
        bus.start = 1'b0;
        reset = 1'b1;
        repeat (2) cyc();

        run(0, 1'b1, 324);   // random valid, start noise while busy
        run(1, 1'b0, 324);   // bursty two-on one-off
        run(3, 1'b0, 324);   // valid held high past the tile
        run(2, 1'b0, 30);    // only 30 rows: DRAIN timeout on kij 0
        chk("err_sticky", 64'(bus.err), 64'(1));

        // restart clears err, then reset lands mid-ACT
        mode = 0;
        bus.start = 1'b1;
        begin
            int n;
            n = 0;
            do begin cyc(); n++; end while (!(m_run && m_kij == 0 && m_pos == 50) && n < 200);
            chk("act_reached", 64'(n < 200), 64'(1));
        end
        chk("err_cleared", 64'(bus.err), 64'(0));
        reset = 1'b0;
        #1;
        chk("mid_inst", 64'(bus.inst), 64'(IDLE_W));
        chk("mid_busy", 64'(bus.busy), 64'(0));
        chk("mid_done", 64'(bus.done), 64'(0));
        chk("mid_kij", 64'(bus.kij), 64'(0));
        m_run = 0; m_next = 0; m_err = 0; m_kij = 0; m_pos = 0; m_rows = 0;
        @(posedge clk); #1;
        reset = 1'b1;
        bus.start = 1'b0;
        repeat (3) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
